// File: rtl/dmem_port.sv
// MEM-stage data-memory port: turns load/store control into a held d-cache request,
// shifts store data into byte lanes and sign/zero-extends returned load data.
module dmem_port #(
    parameter int unsigned TIMEOUT = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_read,
    input  logic        req_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic [31:0] rdata,
    output logic        done,
    output logic        misaligned,
    output logic        timeout_err,
    output logic        dmem_read,
    output logic        dmem_write,
    output logic [31:0] dmem_address,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_mbe,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_resp,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    // Handshake: a request is presented on dmem_read/dmem_write from the cycle after
    // acceptance and held until the single-cycle dmem_resp; the cache may respond in
    // any BUSY cycle, and a response outside BUSY is ignored.

    state_t      state, state_nxt;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [2:0]  f3_q;
    logic        wr_q;
    logic [1:0]  size_q;
    logic [31:0] rdata_q;
    logic [31:0] cnt_q;

    logic        req_any;
    logic [1:0]  size_in;
    logic        mis;
    logic        accept;
    logic        timeout_hit;
    logic [31:0] load_val;
    logic [3:0]  be;

    // Stores treat every funct3 other than sb/sh as a word; loads decode size from
    // funct3[1:0] so lbu/lhu map onto byte/half.
    function automatic logic [1:0] access_size(input logic is_wr, input logic [2:0] f3);
        logic [1:0] sz;
        if (is_wr) begin
            sz = (f3 == 3'b000) ? SZ_BYTE : (f3 == 3'b001) ? SZ_HALF : SZ_WORD;
        end else begin
            sz = (f3[1:0] == 2'b00) ? SZ_BYTE : (f3[1:0] == 2'b01) ? SZ_HALF : SZ_WORD;
        end
        return sz;
    endfunction

    function automatic logic [31:0] load_format(input logic [31:0] raw, input logic [1:0] off,
                                                input logic [2:0] f3);
        logic [31:0] s;
        logic [31:0] v;
        s = raw >> {off, 3'b000};
        case (f3)
            3'b000:  v = {{24{s[7]}}, s[7:0]};
            3'b001:  v = {{16{s[15]}}, s[15:0]};
            3'b100:  v = {24'd0, s[7:0]};
            3'b101:  v = {16'd0, s[15:0]};
            default: v = s;
        endcase
        return v;
    endfunction

    assign req_any = req_read | req_write;
    assign size_in = access_size(req_write, funct3);

    always_comb begin
        mis = 1'b0;
        if (size_in == SZ_WORD && addr[1:0] != 2'b00) mis = 1'b1;
        if (size_in == SZ_HALF && addr[0]) mis = 1'b1;
    end

    assign accept      = (state == IDLE) && req_any && !mis;
    assign timeout_hit = (TIMEOUT != 0) && (state == BUSY) && !dmem_resp &&
                         ((cnt_q + 32'd1) == TIMEOUT);
    assign load_val    = load_format(dmem_rdata, addr_q[1:0], f3_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            f3_q    <= '0;
            wr_q    <= 1'b0;
            size_q  <= SZ_BYTE;
            rdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                addr_q  <= addr;
                wdata_q <= wdata;
                f3_q    <= funct3;
                wr_q    <= req_write;
                size_q  <= size_in;
            end
            if (state == BUSY) begin
                cnt_q <= cnt_q + 32'd1;
                if (dmem_resp) begin
                    rdata_q <= load_val;
                end else if (timeout_hit) begin
                    rdata_q <= '0;
                end
            end else begin
                cnt_q <= '0;
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        stall       = 1'b0;
        done        = 1'b0;
        misaligned  = 1'b0;
        timeout_err = 1'b0;
        case (state)
            IDLE: begin
                if (req_any) begin
                    if (mis) begin
                        misaligned = 1'b1;
                    end else begin
                        stall     = 1'b1;
                        state_nxt = BUSY;
                    end
                end
            end
            BUSY: begin
                stall = 1'b1;
                if (dmem_resp) begin
                    state_nxt = DONE;
                end else if (timeout_hit) begin
                    timeout_err = 1'b1;
                    state_nxt   = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Byte enables come from the captured size/offset so the cache sees stable lanes.
    always_comb begin
        be = 4'b1111;
        case (size_q)
            SZ_BYTE: be = 4'b0001 << addr_q[1:0];
            SZ_HALF: be = 4'b0011 << addr_q[1:0];
            default: be = 4'b1111;
        endcase
    end

    assign dmem_read    = (state == BUSY) && !wr_q && !rst;
    assign dmem_write   = (state == BUSY) && wr_q && !rst;
    assign dmem_address = {addr_q[31:2], 2'b00};
    assign dmem_wdata   = wdata_q << {addr_q[1:0], 3'b000};
    assign dmem_mbe     = wr_q ? be : 4'b0000;
    assign rdata        = rdata_q;
    assign dbg_state    = state;

endmodule

// File: tb/tb_dmem_port.sv
// Directed bench for dmem_port: one task per scenario, each checking its own results inline.
module tb_dmem_port;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_read = 1'b0, req_write = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [31:0] addr = '0, wdata = '0, dmem_rdata = '0;
    logic        dmem_resp = 1'b0;
    logic        stall, done, misaligned, timeout_err, dmem_read, dmem_write;
    logic [31:0] rdata, dmem_address, dmem_wdata;
    logic [3:0]  dmem_mbe;
    logic [1:0]  dbg_state;

    logic        t_req_read = 1'b0;
    logic [31:0] t_addr = '0, t_dmem_rdata = '0;
    logic        t_dmem_resp = 1'b0;
    logic        t_stall, t_done, t_misaligned, t_timeout_err, t_dmem_read, t_dmem_write;
    logic [31:0] t_rdata, t_dmem_address, t_dmem_wdata;
    logic [3:0]  t_dmem_mbe;
    logic [1:0]  t_dbg_state;

    int n_checks = 0;
    int n_fail = 0;

    logic [31:0] r_res, r_addr, r_wd;
    logic [3:0]  r_mbe;
    int          r_done, r_stall, r_first;
    logic        r_rd, r_wr, r_rid;

    always #5 clk = ~clk;

    dmem_port #(.TIMEOUT(0)) dut (
        .clk(clk), .rst(rst), .req_read(req_read), .req_write(req_write), .funct3(funct3),
        .addr(addr), .wdata(wdata), .stall(stall), .rdata(rdata), .done(done),
        .misaligned(misaligned), .timeout_err(timeout_err), .dmem_read(dmem_read),
        .dmem_write(dmem_write), .dmem_address(dmem_address), .dmem_wdata(dmem_wdata),
        .dmem_mbe(dmem_mbe), .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
        .dbg_state(dbg_state)
    );

    dmem_port #(.TIMEOUT(4)) dut_t (
        .clk(clk), .rst(rst), .req_read(t_req_read), .req_write(1'b0), .funct3(3'b010),
        .addr(t_addr), .wdata(32'h0), .stall(t_stall), .rdata(t_rdata), .done(t_done),
        .misaligned(t_misaligned), .timeout_err(t_timeout_err), .dmem_read(t_dmem_read),
        .dmem_write(t_dmem_write), .dmem_address(t_dmem_address), .dmem_wdata(t_dmem_wdata),
        .dmem_mbe(t_dmem_mbe), .dmem_rdata(t_dmem_rdata), .dmem_resp(t_dmem_resp),
        .dbg_state(t_dbg_state)
    );

    // Driver: presents a request for one cycle, then scrambles the live inputs so the
    // DUT must work from its captured copy. Response arrives in cycle resp_at.
    task automatic run_access(input logic rd, input logic wr, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] wd, input int resp_at,
                              input logic [31:0] rdat,
                              output logic [31:0] res, output int done_at, output int stall_n,
                              output int req_first, output logic [31:0] addr_seen,
                              output logic [3:0] mbe_seen, output logic [31:0] wdat_seen,
                              output logic rd_seen, output logic wr_seen, output logic req_in_done);
        res = '0; done_at = -1; stall_n = 0; req_first = -1; addr_seen = '0; mbe_seen = '0;
        wdat_seen = '0; rd_seen = 1'b0; wr_seen = 1'b0; req_in_done = 1'b0;
        req_read = rd; req_write = wr; funct3 = f3; addr = a; wdata = wd;
        for (int c = 0; c < 30 && done_at < 0; c++) begin
            if (c == 1) begin
                req_read = 1'b0; req_write = 1'b0; funct3 = 3'b111;
                addr = 32'hFFFF_FFFF; wdata = 32'h5A5A_5A5A;
            end
            dmem_resp  = (c == resp_at);
            dmem_rdata = (c == resp_at) ? rdat : 32'hCCCC_CCCC;
            @(negedge clk);
            if (stall) stall_n++;
            if ((dmem_read || dmem_write) && req_first < 0) begin
                req_first = c; addr_seen = dmem_address; mbe_seen = dmem_mbe; wdat_seen = dmem_wdata;
            end
            if (dmem_read) rd_seen = 1'b1;
            if (dmem_write) wr_seen = 1'b1;
            if (done) begin
                done_at = c; res = rdata; req_in_done = dmem_read || dmem_write;
            end
            @(posedge clk); #1;
        end
        dmem_resp = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b expected 0", stall); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
        n_checks++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h expected 0", rdata); end
        n_checks++; if ({dmem_read, dmem_write} !== 2'b00) begin n_fail++; $display("FAIL reset_req: got %b expected 00", {dmem_read, dmem_write}); end
        n_checks++; if (dmem_mbe !== 4'h0) begin n_fail++; $display("FAIL reset_mbe: got %b expected 0000", dmem_mbe); end
        n_checks++; if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", dbg_state); end
        n_checks++; if ({t_stall, t_done, t_timeout_err, t_dmem_read} !== 4'b0) begin n_fail++; $display("FAIL reset_t_outs: got %b expected 0000", {t_stall, t_done, t_timeout_err, t_dmem_read}); end
        @(posedge clk); #1;
    endtask

    task automatic test_lw();
        run_access(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 3, 32'hDEAD_BEEF,
                   r_res, r_done, r_stall, r_first, r_addr, r_mbe, r_wd, r_rd, r_wr, r_rid);
        n_checks++; if (r_res !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL lw_rdata: got %h expected deadbeef", r_res); end
        n_checks++; if (r_done !== 4) begin n_fail++; $display("FAIL lw_done_cycle: got %0d expected 4", r_done); end
        n_checks++; if (r_stall !== 4) begin n_fail++; $display("FAIL lw_stall_cycles: got %0d expected 4", r_stall); end
        n_checks++; if (r_first !== 1) begin n_fail++; $display("FAIL lw_req_first: got %0d expected 1", r_first); end
        n_checks++; if (r_addr !== 32'h100) begin n_fail++; $display("FAIL lw_address: got %h expected 00000100", r_addr); end
        n_checks++; if ({r_rd, r_wr, r_rid} !== 3'b100) begin n_fail++; $display("FAIL lw_req_kind: got %b expected 100", {r_rd, r_wr, r_rid}); end
        n_checks++; if (r_mbe !== 4'b0000) begin n_fail++; $display("FAIL lw_mbe: got %b expected 0000", r_mbe); end
    endtask

    task automatic test_load_ext();
        run_access(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 1, 32'h80FF_0000,
                   r_res, r_done, r_stall, r_first, r_addr, r_mbe, r_wd, r_rd, r_wr, r_rid);
        n_checks++; if (r_res !== 32'hFFFF_FF80) begin n_fail++; $display("FAIL lb_rdata: got %h expected ffffff80", r_res); end
        n_checks++; if (r_addr !== 32'h100) begin n_fail++; $display("FAIL lb_address: got %h expected 00000100", r_addr); end
        n_checks++; if (r_done !== 2 || r_stall !== 2) begin n_fail++; $display("FAIL lb_min_latency: got done %0d stall %0d expected 2 2", r_done, r_stall); end
        run_access(1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 1, 32'h80FF_0000,
                   r_res, r_done, r_stall, r_first, r_addr, r_mbe, r_wd, r_rd, r_wr, r_rid);
        n_checks++; if (r_res !== 32'h0000_0080) begin n_fail++; $display("FAIL lbu_rdata: got %h expected 00000080", r_res); end
        run_access(1'b1, 1'b0, 3'b001, 32'h102, 32'h0, 2, 32'h80FF_0000,
                   r_res, r_done, r_stall, r_first, r_addr, r_mbe, r_wd, r_rd, r_wr, r_rid);
        n_checks++; if (r_res !== 32'hFFFF_80FF) begin n_fail++; $display("FAIL lh_rdata: got %h expected ffff80ff", r_res); end
        run_access(1'b1, 1'b0, 3'b101, 32'h102, 32'h0, 1, 32'h80FF_0000,
                   r_res, r_done, r_stall, r_first, r_addr, r_mbe, r_wd, r_rd, r_wr, r_rid);
        n_checks++; if (r_res !== 32'h0000_80FF) begin n_fail++; $display("FAIL lhu_rdata: got %h expected 000080ff", r_res); end
        run_access(1'b1, 1'b0, 3'b011, 32'h104, 32'h0, 1, 32'h80FF_0000,
                   r_res, r_done, r_stall, r_first, r_addr, r_mbe, r_wd, r_rd, r_wr, r_rid);
        n_checks++; if (r_res !== 32'h80FF_0000) begin n_fail++; $display("FAIL rsvd_load_rdata: got %h expected 80ff0000", r_res); end
    endtask

    task automatic test_store();
        run_access(1'b0, 1'b1, 3'b000, 32'h201, 32'h0000_00AB, 2, 32'h0,
                   r_res, r_done, r_stall, r_first, r_addr, r_mbe, r_wd, r_rd, r_wr, r_rid);
        n_checks++; if (r_mbe !== 4'b0010) begin n_fail++; $display("FAIL sb_mbe: got %b expected 0010", r_mbe); end
        n_checks++; if (r_wd !== 32'h0000_AB00) begin n_fail++; $display("FAIL sb_wdata: got %h expected 0000ab00", r_wd); end
        n_checks++; if (r_addr !== 32'h200) begin n_fail++; $display("FAIL sb_address: got %h expected 00000200", r_addr); end
        n_checks++; if ({r_rd, r_wr, r_rid} !== 3'b010 || r_done !== 3) begin n_fail++; $display("FAIL sb_handshake: got kind %b done %0d expected 010 3", {r_rd, r_wr, r_rid}, r_done); end
        run_access(1'b0, 1'b1, 3'b001, 32'h202, 32'h0000_1234, 1, 32'h0,
                   r_res, r_done, r_stall, r_first, r_addr, r_mbe, r_wd, r_rd, r_wr, r_rid);
        n_checks++; if (r_mbe !== 4'b1100) begin n_fail++; $display("FAIL sh_mbe: got %b expected 1100", r_mbe); end
        n_checks++; if (r_wd !== 32'h1234_0000) begin n_fail++; $display("FAIL sh_wdata: got %h expected 12340000", r_wd); end
        run_access(1'b0, 1'b1, 3'b100, 32'h204, 32'hCAFE_F00D, 1, 32'h0,
                   r_res, r_done, r_stall, r_first, r_addr, r_mbe, r_wd, r_rd, r_wr, r_rid);
        n_checks++; if (r_mbe !== 4'b1111 || r_wd !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL rsvd_store: got mbe %b wdata %h expected 1111 cafef00d", r_mbe, r_wd); end
        run_access(1'b1, 1'b1, 3'b010, 32'h208, 32'h0102_0304, 1, 32'h0,
                   r_res, r_done, r_stall, r_first, r_addr, r_mbe, r_wd, r_rd, r_wr, r_rid);
        n_checks++; if ({r_rd, r_wr} !== 2'b01 || r_mbe !== 4'b1111) begin n_fail++; $display("FAIL rw_both_is_write: got kind %b mbe %b expected 01 1111", {r_rd, r_wr}, r_mbe); end
    endtask

    task automatic test_misaligned();
        logic [31:0] a_tab [2] = '{32'h102, 32'h203};
        logic [2:0]  f_tab [2] = '{3'b010, 3'b001};
        logic        w_tab [2] = '{1'b0, 1'b1};
        for (int i = 0; i < 2; i++) begin
            int req_cnt;
            req_cnt = 0;
            req_read = !w_tab[i]; req_write = w_tab[i]; funct3 = f_tab[i]; addr = a_tab[i];
            wdata = 32'h1111_2222;
            @(negedge clk);
            n_checks++; if (misaligned !== 1'b1 || stall !== 1'b0) begin n_fail++; $display("FAIL misaligned_pulse_%0d: got mis %b stall %b expected 1 0", i, misaligned, stall); end
            if (dmem_read || dmem_write) req_cnt++;
            @(posedge clk); #1;
            req_read = 1'b0; req_write = 1'b0;
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                if (dmem_read || dmem_write || stall || done || misaligned) req_cnt++;
                @(posedge clk); #1;
            end
            n_checks++; if (req_cnt !== 0 || dbg_state !== 2'd0) begin n_fail++; $display("FAIL misaligned_no_access_%0d: got activity %0d state %0d expected 0 0", i, req_cnt, dbg_state); end
        end
    endtask

    task automatic test_reset_busy();
        int act;
        act = 0;
        req_read = 1'b1; funct3 = 3'b010; addr = 32'h100;
        @(posedge clk); #1;
        req_read = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; dmem_resp = 1'b1; dmem_rdata = 32'h1111_1111;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (done || dmem_read || dmem_write || stall) act++;
            @(posedge clk); #1;
            dmem_resp = 1'b0;
        end
        n_checks++; if (act !== 0 || dbg_state !== 2'd0) begin n_fail++; $display("FAIL rst_in_busy: got activity %0d state %0d expected 0 0", act, dbg_state); end
        run_access(1'b1, 1'b0, 3'b010, 32'h108, 32'h0, 2, 32'h0BAD_F00D,
                   r_res, r_done, r_stall, r_first, r_addr, r_mbe, r_wd, r_rd, r_wr, r_rid);
        n_checks++; if (r_res !== 32'h0BAD_F00D || r_done !== 3) begin n_fail++; $display("FAIL lw_after_rst: got %h done %0d expected 0badf00d 3", r_res, r_done); end
    endtask

    task automatic test_back_to_back();
        run_access(1'b1, 1'b0, 3'b010, 32'h300, 32'h0, 1, 32'h1234_5678,
                   r_res, r_done, r_stall, r_first, r_addr, r_mbe, r_wd, r_rd, r_wr, r_rid);
        n_checks++; if (r_res !== 32'h1234_5678 || r_done !== 2 || r_rid !== 1'b0) begin n_fail++; $display("FAIL b2b_lw: got %h done %0d req_in_done %b expected 12345678 2 0", r_res, r_done, r_rid); end
        run_access(1'b0, 1'b1, 3'b010, 32'h304, 32'h9ABC_DEF0, 1, 32'h0,
                   r_res, r_done, r_stall, r_first, r_addr, r_mbe, r_wd, r_rd, r_wr, r_rid);
        n_checks++; if (r_wr !== 1'b1 || r_first !== 1 || r_done !== 2) begin n_fail++; $display("FAIL b2b_sw_handshake: got wr %b first %0d done %0d expected 1 1 2", r_wr, r_first, r_done); end
        n_checks++; if (r_addr !== 32'h304 || r_wd !== 32'h9ABC_DEF0 || r_mbe !== 4'b1111) begin n_fail++; $display("FAIL b2b_sw_data: got %h %h %b expected 00000304 9abcdef0 1111", r_addr, r_wd, r_mbe); end
    endtask

    task automatic test_timeout();
        int d_at, e_at, st_n;
        logic [31:0] d_val;
        logic req_at_done;
        d_at = -1; d_val = '0;
        t_req_read = 1'b1; t_addr = 32'h40;
        for (int c = 0; c < 20 && d_at < 0; c++) begin
            if (c == 1) t_req_read = 1'b0;
            t_dmem_resp = (c == 2); t_dmem_rdata = (c == 2) ? 32'h7777_7777 : 32'h0;
            @(negedge clk);
            if (t_done) begin d_at = c; d_val = t_rdata; end
            @(posedge clk); #1;
        end
        t_dmem_resp = 1'b0;
        n_checks++; if (d_val !== 32'h7777_7777 || d_at !== 3) begin n_fail++; $display("FAIL t_normal: got %h done %0d expected 77777777 3", d_val, d_at); end
        d_at = -1; e_at = -1; st_n = 0; d_val = 32'hFFFF_FFFF; req_at_done = 1'b1;
        t_req_read = 1'b1; t_addr = 32'h44; t_dmem_rdata = 32'h5555_5555;
        for (int c = 0; c < 20 && d_at < 0; c++) begin
            if (c == 1) t_req_read = 1'b0;
            @(negedge clk);
            if (t_stall) st_n++;
            if (t_timeout_err && e_at < 0) e_at = c;
            if (t_done) begin d_at = c; d_val = t_rdata; req_at_done = t_dmem_read; end
            @(posedge clk); #1;
        end
        n_checks++; if (e_at !== 4) begin n_fail++; $display("FAIL timeout_err_cycle: got %0d expected 4", e_at); end
        n_checks++; if (d_at !== 5 || d_val !== 32'h0) begin n_fail++; $display("FAIL timeout_done: got cycle %0d rdata %h expected 5 00000000", d_at, d_val); end
        n_checks++; if (st_n !== 5 || req_at_done !== 1'b0) begin n_fail++; $display("FAIL timeout_stall: got stall %0d req %b expected 5 0", st_n, req_at_done); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_lw();
        test_load_ext();
        test_store();
        test_misaligned();
        test_reset_busy();
        test_back_to_back();
        test_timeout();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
